// File: rtl/ioctl_router_pkg.sv
// ioctl_router_pkg: region modes, clog2 and address-to-region lookup shared by the ioctl ROM router
package ioctl_router_pkg;
  typedef enum logic [1:0] {
    MODE_LINEAR = 2'd0,
    MODE_SPLIT  = 2'd1,
    MODE_PROM   = 2'd2,
    MODE_SKIP   = 2'd3
  } mode_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Returns the lowest region whose exclusive end lies above addr; nreg means out of range.
  function automatic logic [3:0] region_of(input logic [24:0] addr, input logic [199:0] reg_end, input int nreg);
    logic [3:0] r;
    r = 4'(nreg);
    for (int i = 7; i >= 0; i--)
      if (i < nreg && addr < reg_end[i*25 +: 25]) r = 4'(i);
    return r;
  endfunction
endpackage

// File: rtl/ioctl_router_fifo.sv
// ioctl_router_fifo: show-ahead FIFO with full/empty flags and simultaneous push/pop, async reset
// Ports: clk_sys, reset, push/din in, pop in, dout (head), full, empty.
module ioctl_router_fifo
  import ioctl_router_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW:0] wp, rp;
  logic do_pop, do_push;
  assign empty = wp == rp;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign dout = mem[rp[PW-1:0]];
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk_sys)
    if (do_push) mem[wp[PW-1:0]] <= din;
endmodule

// File: rtl/ioctl_rom_router.sv
// ioctl_rom_router: routes the ioctl download byte stream into LINEAR/SPLIT/PROM/SKIP regions, packing bytes for a queued memory port
// Ports: clk_sys, reset (async, active-high); ioctl_download/wr/addr/dout from hps_io;
// mem_addr/din/be/we with mem_ready toward ROM memory; prom_we/addr/din PROM port; busy, ovf, done, csum status.
// Optional: IOCTL_ROUTER_CSUM_EN enables the running byte checksum on csum (tied to 0 otherwise).
module ioctl_rom_router
  import ioctl_router_pkg::*;
#(
  parameter int                  NREG       = 3,
  parameter logic [NREG*25-1:0]  REG_END    = {25'd240128, 25'd237568, 25'd106496},
  parameter logic [NREG*2-1:0]   REG_MODE   = {MODE_PROM, MODE_SPLIT, MODE_LINEAR},
  parameter int                  SPLIT_BIT  = 14,
  parameter int                  LANES      = 2,
  parameter int                  AW         = 17,
  parameter int                  FIFO_DEPTH = 4
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic [AW-1:0]       mem_addr,
  output logic [8*LANES-1:0]  mem_din,
  output logic [LANES-1:0]    mem_be,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic [NREG-1:0]     prom_we,
  output logic [7:0]          prom_addr,
  output logic [7:0]          prom_din,
  output logic                busy,
  output logic                ovf,
  output logic                done,
  output logic [15:0]         csum
);
  localparam int LB = clog2(LANES);
  localparam int DW = 8 * LANES;
  localparam int EW = AW + DW + LANES;
  localparam logic [199:0] END_X = 200'(REG_END);
  localparam logic [15:0] MODE_X = 16'(REG_MODE);
  logic [3:0] r;
  logic [2:0] rr;
  logic in_rng, go, fifo_go, prom_go;
  logic [24:0] start, off, split_off, word;
  mode_t md;
  logic [LB-1:0] lane;
  logic [DW-1:0] din_sh;
  logic [LANES-1:0] be;
  logic s1_valid, dl_q, dl_rise, dl_fall, armed, idle, full, empty, pop, push_ok;
  logic [EW-1:0] s1_entry, head;
  always_comb begin
    r = region_of(ioctl_addr, END_X, NREG);
    in_rng = r < 4'(NREG);
    rr = in_rng ? r[2:0] : 3'd0;
    start = rr == 3'd0 ? 25'd0 : END_X[3'(rr - 3'd1)*25 +: 25];
    off = ioctl_addr - start;
    // SPLIT squeezes the lane-select bit out of the offset to form the word index.
    split_off = ((off >> (SPLIT_BIT + 1)) << SPLIT_BIT) | (off & 25'((1 << SPLIT_BIT) - 1));
    md = mode_t'(MODE_X[rr*2 +: 2]);
    lane = md == MODE_SPLIT ? LB'(off[SPLIT_BIT]) : off[LB-1:0];
    word = md == MODE_SPLIT ? start / 25'd2 + split_off : start / 25'(LANES) + off / 25'(LANES);
    din_sh = DW'(ioctl_dout) << (8 * lane);
    be = LANES'(1) << lane;
    go = ioctl_wr & ioctl_download & in_rng;
    fifo_go = go & (md == MODE_LINEAR || md == MODE_SPLIT);
    prom_go = go & (md == MODE_PROM);
  end
  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign mem_we = ~empty;
  assign busy = ~empty;
  assign pop = mem_we & mem_ready;
  assign push_ok = s1_valid & (~full | pop);
  assign idle = empty & ~s1_valid;
  assign mem_addr = mem_we ? head[EW-1 -: AW] : '0;
  assign mem_din = mem_we ? head[DW+LANES-1 : LANES] : '0;
  assign mem_be = mem_we ? head[LANES-1:0] : '0;
  ioctl_router_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys(clk_sys),
    .reset(reset),
    .push(s1_valid),
    .din(s1_entry),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
      prom_we <= '0;
      prom_addr <= '0;
      prom_din <= '0;
      dl_q <= 1'b0;
      ovf <= 1'b0;
      armed <= 1'b0;
      done <= 1'b0;
    end else begin
      s1_valid <= fifo_go;
      s1_entry <= {AW'(word), din_sh, be};
      prom_we <= prom_go ? NREG'(1) << rr : '0;
      prom_addr <= prom_go ? off[7:0] : '0;
      prom_din <= prom_go ? ioctl_dout : '0;
      dl_q <= ioctl_download;
      ovf <= dl_rise ? 1'b0 : ovf | (s1_valid & full & ~pop);
      armed <= (armed | dl_fall) & ~idle;
      done <= (armed | dl_fall) & idle;
    end
`ifdef IOCTL_ROUTER_CSUM_EN
  logic [7:0] s1_byte;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      s1_byte <= '0;
      csum <= '0;
    end else begin
      s1_byte <= ioctl_dout;
      csum <= dl_rise ? 16'd0 : csum + ((push_ok | (|prom_we)) ? 16'(s1_byte) : 16'd0);
    end
`else
  assign csum = '0;
`endif
endmodule

// File: tb/tb_ioctl_rom_router.sv
// tb_ioctl_rom_router: table-driven and sequence checks of the ioctl ROM router
module tb_ioctl_rom_router;
  import ioctl_router_pkg::*;
  logic clk_sys, reset, ioctl_download, ioctl_wr, mem_ready;
  logic [24:0] ioctl_addr;
  logic [7:0] ioctl_dout, prom_addr, prom_din;
  logic [16:0] mem_addr;
  logic [15:0] mem_din, csum;
  logic [1:0] mem_be;
  logic [2:0] prom_we;
  logic mem_we, busy, ovf, done;
  int n_chk, n_fail, done_cnt;
  logic [15:0] exp_csum;
  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    logic        fw;
    logic [16:0] wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [2:0]  pw;
    logic [7:0]  pa;
  } vec_t;
  vec_t v [11];
  logic [16:0] bp_a [4];
  logic [15:0] bp_d [4];
  logic [1:0] bp_b [4];
  ioctl_rom_router #(
    .NREG(3),
    .REG_END({25'd240128, 25'd237568, 25'd106496}),
    .REG_MODE({MODE_PROM, MODE_SPLIT, MODE_LINEAR}),
    .SPLIT_BIT(14),
    .LANES(2),
    .AW(17),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_be(mem_be),
    .mem_we(mem_we),
    .mem_ready(mem_ready),
    .prom_we(prom_we),
    .prom_addr(prom_addr),
    .prom_din(prom_din),
    .busy(busy),
    .ovf(ovf),
    .done(done),
    .csum(csum)
  );
  always #5 clk_sys = ~clk_sys;
  always @(negedge clk_sys) if (!reset && done) done_cnt++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask
  initial begin
    int k, d0;
    clk_sys = 0; reset = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_dout = '0; mem_ready = 1;
    n_chk = 0; n_fail = 0; done_cnt = 0; exp_csum = '0;
    v[0]  = '{25'd1,      8'hA5, 1'b1, 17'd0,      16'hA500, 2'b10, 3'b000, 8'h00};
    v[1]  = '{25'd0,      8'h3C, 1'b1, 17'd0,      16'h003C, 2'b01, 3'b000, 8'h00};
    v[2]  = '{25'd106495, 8'h77, 1'b1, 17'd53247,  16'h7700, 2'b10, 3'b000, 8'h00};
    v[3]  = '{25'd122883, 8'h5A, 1'b1, 17'd53251,  16'h5A00, 2'b10, 3'b000, 8'h00};
    v[4]  = '{25'd106499, 8'h11, 1'b1, 17'd53251,  16'h0011, 2'b01, 3'b000, 8'h00};
    v[5]  = '{25'd106496, 8'h22, 1'b1, 17'd53248,  16'h0022, 2'b01, 3'b000, 8'h00};
    v[6]  = '{25'd237567, 8'h99, 1'b1, 17'd118783, 16'h9900, 2'b10, 3'b000, 8'h00};
    v[7]  = '{25'd237829, 8'h0C, 1'b0, 17'd0,      16'h0000, 2'b00, 3'b100, 8'h05};
    v[8]  = '{25'd240127, 8'hE7, 1'b0, 17'd0,      16'h0000, 2'b00, 3'b100, 8'hFF};
    v[9]  = '{25'd240128, 8'h44, 1'b0, 17'd0,      16'h0000, 2'b00, 3'b000, 8'h00};
    v[10] = '{25'h1FFFFFF, 8'h55, 1'b0, 17'd0,     16'h0000, 2'b00, 3'b000, 8'h00};
    bp_a = '{17'h80, 17'h80, 17'h81, 17'h81};
    bp_d = '{16'h0010, 16'h1100, 16'h0012, 16'h1300};
    bp_b = '{2'b01, 2'b10, 2'b01, 2'b10};
    repeat (3) @(negedge clk_sys);
    reset = 0;
    @(negedge clk_sys);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    chk("rst_prom_we", prom_we, 0);
    chk("rst_csum", csum, 0);
    ioctl_download = 1;
    @(negedge clk_sys);
    for (int i = 0; i < 11; i++) begin
      ioctl_addr = v[i].a;
      ioctl_dout = v[i].d;
      ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      chk($sformatf("v%0d_prom_we", i), prom_we, v[i].pw);
      chk($sformatf("v%0d_prom_addr", i), prom_addr, v[i].pa);
      chk($sformatf("v%0d_prom_din", i), prom_din, v[i].pw != 0 ? v[i].d : 8'h00);
      chk($sformatf("v%0d_mem_we_n1", i), mem_we, 0);
      @(negedge clk_sys);
      chk($sformatf("v%0d_mem_we", i), mem_we, v[i].fw);
      if (v[i].fw) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr, v[i].wa);
        chk($sformatf("v%0d_mem_din", i), mem_din, v[i].wd);
        chk($sformatf("v%0d_mem_be", i), mem_be, v[i].be);
      end
      if (v[i].fw || v[i].pw != 0) exp_csum += 16'(v[i].d);
    end
    @(negedge clk_sys);
`ifdef IOCTL_ROUTER_CSUM_EN
    chk("table_csum", csum, exp_csum);
`else
    chk("table_csum", csum, 0);
`endif
    chk("table_ovf", ovf, 0);
    mem_ready = 0;
    for (int j = 0; j < 5; j++) wr_byte(25'h100 + 25'(j), 8'h10 + 8'(j));
    repeat (2) @(negedge clk_sys);
    chk("bp_busy", busy, 1);
    chk("bp_ovf", ovf, 1);
    mem_ready = 1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_we && mem_ready) begin
        if (k < 4) begin
          chk($sformatf("bp%0d_addr", k), mem_addr, bp_a[k]);
          chk($sformatf("bp%0d_din", k), mem_din, bp_d[k]);
          chk($sformatf("bp%0d_be", k), mem_be, bp_b[k]);
        end
        k++;
      end
      @(negedge clk_sys);
    end
    chk("bp_count", k, 4);
    chk("bp_drained", busy, 0);
    ioctl_download = 0;
    repeat (3) @(negedge clk_sys);
    ioctl_download = 1;
    repeat (2) @(negedge clk_sys);
    chk("rise_ovf", ovf, 0);
    chk("rise_csum", csum, 0);
    mem_ready = 0;
    wr_byte(25'h200, 8'h31);
    wr_byte(25'h201, 8'h32);
    @(negedge clk_sys);
    chk("rq_busy", busy, 1);
    #2;
    reset = 1;
    ioctl_download = 0;
    d0 = done_cnt;
    @(negedge clk_sys);
    reset = 0;
    chk("rq_mem_we", mem_we, 0);
    chk("rq_busy0", busy, 0);
    mem_ready = 1;
    repeat (6) @(negedge clk_sys);
    chk("rq_mem_we_late", mem_we, 0);
    chk("rq_no_done", done_cnt - d0, 0);
    ioctl_download = 1;
    repeat (2) @(negedge clk_sys);
    wr_byte(25'd240128, 8'h44);
    chk("oor_prom_we", prom_we, 0);
    @(negedge clk_sys);
    chk("oor_mem_we", mem_we, 0);
    chk("oor_csum", csum, 0);
    wr_byte(25'h10, 8'hFF);
    wr_byte(25'd237568, 8'h02);
    repeat (4) @(negedge clk_sys);
`ifdef IOCTL_ROUTER_CSUM_EN
    chk("csum_0101", csum, 16'h0101);
`else
    chk("csum_0101", csum, 0);
`endif
    d0 = done_cnt;
    ioctl_download = 0;
    repeat (8) @(negedge clk_sys);
    chk("done_once", done_cnt - d0, 1);
    wr_byte(25'h0, 8'h66);
    chk("nodl_prom_we", prom_we, 0);
    @(negedge clk_sys);
    chk("nodl_mem_we", mem_we, 0);
    chk("nodl_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
